// File: rtl/logic_seq_pkg.sv
// Shared types and defaults for the byte-serial 32-bit logic-op sequencer.
package logic_seq_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SLICE = 8;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  // Code 2'b11 is unused and recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/byte_logic_slice.sv
// Shared combinational logic slice: applies AND/OR/XOR/NOR to one operand slice.
module byte_logic_slice
  import logic_seq_pkg::*;
#(
  parameter int unsigned W = DEF_SLICE
) (
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic32_seq_ctrl.sv
// Byte-serial sequencer for 32-bit bitwise ops; one shared slice over NSLICE cycles.
// Optional zero flag output enabled by defining LOGIC_ZERO_FLAG_EN.
module logic32_seq_ctrl
  import logic_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
`ifdef LOGIC_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  state_e            state;
  state_e            next_state;
  logic [CNT_W-1:0]  cnt;
  op_e               op_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [SLICE-1:0]  slice_a;
  logic [SLICE-1:0]  slice_b;
  logic [SLICE-1:0]  slice_y;
  logic              accept;
  logic              last;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == CNT_LAST);

  // Counter picks which operand slice feeds the shared logic slice.
  assign slice_a = a_q[cnt*SLICE +: SLICE];
  assign slice_b = b_q[cnt*SLICE +: SLICE];

  byte_logic_slice #(
    .W (SLICE)
  ) u_slice (
    .op (op_q),
    .a  (slice_a),
    .b  (slice_b),
    .y  (slice_y)
  );

  // State register; out_valid/busy are flopped decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      out_valid <= (next_state == S_DONE);
      busy      <= (next_state == S_RUN) || (next_state == S_DONE);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = S_RUN;
      S_RUN:   if (last) next_state = S_DONE;
      S_DONE:  if (out_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Operand latch, byte counter and result assembly, LSB slice first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_q   <= OP_AND;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
    end else if (accept) begin
      cnt  <= '0;
      op_q <= op_e'(op);
      a_q  <= a;
      b_q  <= b;
    end else if (state == S_RUN) begin
      result[cnt*SLICE +: SLICE] <= slice_y;
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end

`ifdef LOGIC_ZERO_FLAG_EN
  logic [WIDTH-1:0] final_result;

  // The last slice is still in flight, so merge it before testing for zero.
  always_comb begin
    final_result = result;
    final_result[cnt*SLICE +: SLICE] = slice_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
    end else if ((state == S_RUN) && last) begin
      zero <= (final_result == '0);
    end
  end
`endif

endmodule
